// File: rtl/spi_att_sched_if.sv
// Bus between the attenuator scheduler and the rest of the system: the
// register-write side, the serializer start/done handshake and status.
interface spi_att_sched_if #(
  parameter int N_CS   = 16,
  parameter int CS_W   = 4,
  parameter int N_BITS = 8
);
  logic              wr_en;
  logic [CS_W-1:0]   wr_addr;
  logic [N_BITS-1:0] wr_data;
  logic              refresh;
  logic              err_clr;
  logic              shf_start;
  logic [CS_W-1:0]   shf_cs;
  logic [N_BITS-1:0] shf_data;
  logic              shf_done;
  logic [N_CS-1:0]   pending;
  logic              idle;
  logic              err;

  // Host/serializer side of the scheduler
  modport master (
    output wr_en, wr_addr, wr_data, refresh, err_clr, shf_done,
    input  shf_start, shf_cs, shf_data, pending, idle, err
  );

  // The scheduler itself
  modport slave (
    input  wr_en, wr_addr, wr_data, refresh, err_clr, shf_done,
    output shf_start, shf_cs, shf_data, pending, idle, err
  );
endinterface

// File: rtl/spi_att_sched.sv
// Attenuator transfer scheduler: keeps one word per device, flags devices
// needing programming and round-robin issues one serializer transfer at a time.
module spi_att_sched #(
  parameter int                N_CS     = 16,
  parameter int                CS_W     = 4,
  parameter int                N_BITS   = 8,
  parameter logic [N_BITS-1:0] INIT_ATT = '1,
  parameter int                TIMEOUT  = 4096
) (
  input  logic           clk,
  input  logic           reset,
  spi_att_sched_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] att_q [N_CS];
  logic [N_CS-1:0]   pending_q, pending_d;
  logic [CS_W-1:0]   rr_q;
  logic [CS_W-1:0]   sel_q;
  logic [CS_W-1:0]   shf_cs_q;
  logic [N_BITS-1:0] shf_data_q;
  logic              err_q;
  logic [CNT_W-1:0]  cntr_q;

  logic              wr_valid;
  logic              tmo_hit;
  logic              arb_found;
  logic [CS_W-1:0]   arb_sel;
  int                arb_idx;
  logic              arb_load;
  logic              issue;
  logic              tmo_fire;

  assign wr_valid = bus.wr_en && (32'(bus.wr_addr) < N_CS);
  assign tmo_hit  = (TIMEOUT != 0) && (cntr_q == TO_LAST);

  // Round-robin pick: first pending device after the last one served
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = 0;
    for (int i = 1; i <= N_CS; i++) begin
      arb_idx = int'(rr_q) + i;
      if (arb_idx >= N_CS) arb_idx = arb_idx - N_CS;
      if (!arb_found && pending_q[CS_W'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_sel   = CS_W'(arb_idx);
      end
    end
  end

  // State register; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: arbitrate, issue for one cycle, then wait for done or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending_q) state_d = ARB;
      ARB:     state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.shf_done || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-state strobes; a done arriving on the timeout cycle suppresses the timeout
  always_comb begin
    arb_load = 1'b0;
    issue    = 1'b0;
    tmo_fire = 1'b0;
    case (state_q)
      ARB:     arb_load = 1'b1;
      ISSUE:   issue    = 1'b1;
      WAIT:    tmo_fire = tmo_hit && !bus.shf_done;
      default: ;
    endcase
  end

  // Pending flags: sets from writes, refresh and timeout retry beat the issue clear
  always_comb begin
    pending_d = pending_q;
    if (issue)         pending_d[sel_q]       = 1'b0;
    if (tmo_fire)      pending_d[sel_q]       = 1'b1;
    if (bus.refresh)   pending_d              = '1;
    if (wr_valid)      pending_d[bus.wr_addr] = 1'b1;
  end

  // Datapath: word store, selection snapshot, rr pointer, timeout counter, sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CS; i++) att_q[i] <= INIT_ATT;
      pending_q  <= '1;
      rr_q       <= CS_W'(N_CS - 1);
      sel_q      <= '0;
      shf_cs_q   <= '0;
      shf_data_q <= '0;
      err_q      <= 1'b0;
      cntr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_valid) att_q[bus.wr_addr] <= bus.wr_data;
      if (arb_load) begin
        sel_q    <= arb_sel;
        shf_cs_q <= arb_sel;
        // A write landing during ARB is forwarded so the issued word matches att[sel]
        shf_data_q <= (wr_valid && (bus.wr_addr == arb_sel)) ? bus.wr_data : att_q[arb_sel];
      end
      if (issue) begin
        rr_q   <= sel_q;
        cntr_q <= '0;
      end else if (state_q == WAIT) begin
        cntr_q <= cntr_q + 1'b1;
      end
      if (tmo_fire)         err_q <= 1'b1;
      else if (bus.err_clr) err_q <= 1'b0;
    end
  end

  assign bus.shf_start = issue;
  assign bus.shf_cs    = shf_cs_q;
  assign bus.shf_data  = shf_data_q;
  assign bus.pending   = pending_q;
  assign bus.idle      = (state_q == IDLE) && (pending_q == '0);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_spi_att_sched.sv
// Bench for spi_att_sched: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_spi_att_sched;
  localparam int N_CS    = 16;
  localparam int CS_W    = 4;
  localparam int N_BITS  = 8;
  localparam int TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  spi_att_sched_if #(.N_CS(N_CS), .CS_W(CS_W), .N_BITS(N_BITS)) bus ();

  spi_att_sched #(
    .N_CS(N_CS), .CS_W(CS_W), .N_BITS(N_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: cycle numbers of upcoming arbitration/issue and of the
  // transfer in flight, plus the device table as software sees it.
  int                cyc       = 0;
  int                arbAt     = -1;
  int                issueAt   = -1;
  int                startedAt = -1;
  int                freeFrom  = 0;
  int                mRr;
  int                mSel;
  logic              mErr;
  logic [N_CS-1:0]   mPend;
  logic [N_BITS-1:0] mAtt [N_CS];
  logic [CS_W-1:0]   expCs;
  logic [N_BITS-1:0] expData;

  int doneDelay = 10;
  int doneCnt   = 0;
  int noiseOn   = 0;
  int logCs[$];
  int logData[$];
  int logCyc[$];

  function automatic int rrPick(input logic [N_CS-1:0] p, input int rr);
    for (int i = 1; i <= N_CS; i++) begin
      if (p[(rr + i) % N_CS]) return (rr + i) % N_CS;
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    arbAt = -1; issueAt = -1; startedAt = -1; freeFrom = 0;
    mRr = N_CS - 1; mSel = 0; mErr = 1'b0; mPend = '1;
    for (int i = 0; i < N_CS; i++) mAtt[i] = '1;
    expCs = '0; expData = '0;
    doneCnt = 0;
  endtask

  // Advance the model over one clock edge using the inputs of the cycle just ended
  task automatic modelStep();
    int p, n;
    logic [N_CS-1:0] newPend;
    logic tmo;
    p = cyc; n = cyc + 1;
    newPend = mPend;
    tmo = 1'b0;
    if (issueAt == p) begin
      newPend[mSel] = 1'b0;
      mRr = mSel;
      startedAt = p;
      issueAt = -1;
    end else if (startedAt >= 0) begin
      if (bus.shf_done) begin
        startedAt = -1; freeFrom = n;
      end else if (p - startedAt == TIMEOUT) begin
        tmo = 1'b1; newPend[mSel] = 1'b1; startedAt = -1; freeFrom = n;
      end
    end
    if (arbAt == p) begin
      mSel = rrPick(mPend, mRr);
      issueAt = n;
      arbAt = -1;
    end else if (startedAt < 0 && issueAt < 0 && p >= freeFrom && mPend != '0) begin
      arbAt = n;
    end
    if (bus.refresh) newPend = '1;
    if (bus.wr_en && (int'(bus.wr_addr) < N_CS)) begin
      newPend[bus.wr_addr] = 1'b1;
      mAtt[bus.wr_addr] = bus.wr_data;
    end
    if (tmo) mErr = 1'b1;
    else if (bus.err_clr) mErr = 1'b0;
    mPend = newPend;
    cyc = n;
    if (issueAt == n) begin
      expCs = CS_W'(mSel);
      expData = mAtt[mSel];
    end
  endtask

  task automatic compareAll();
    logic mIdle;
    mIdle = (startedAt < 0) && (arbAt < 0) && (issueAt < 0) && (mPend == '0);
    checkOutput("shf_start", 64'(bus.shf_start), 64'(issueAt == cyc));
    checkOutput("shf_cs",    64'(bus.shf_cs),    64'(expCs));
    checkOutput("shf_data",  64'(bus.shf_data),  64'(expData));
    checkOutput("pending",   64'(bus.pending),   64'(mPend));
    checkOutput("err",       64'(bus.err),       64'(mErr));
    checkOutput("idle",      64'(bus.idle),      64'(mIdle));
  endtask

  // Serializer stand-in: done pulse doneDelay cycles after each start (0 = never)
  task automatic respondDone();
    bus.shf_done = 1'b0;
    if (bus.shf_start) begin
      doneCnt = doneDelay;
    end else if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) bus.shf_done = 1'b1;
    end
    if (noiseOn != 0 && !bus.shf_done && $urandom_range(0, 29) == 0) bus.shf_done = 1'b1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (!reset) modelStep();
    @(negedge clk);
    if (!reset) begin
      compareAll();
      if (bus.shf_start) begin
        logCs.push_back(int'(bus.shf_cs));
        logData.push_back(int'(bus.shf_data));
        logCyc.push_back(cyc);
      end
    end
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.refresh = 1'b0; bus.err_clr = 1'b0;
    respondDone();
  endtask

  task automatic applyStimulus(input logic we, input int addr, input int data,
                               input logic rf, input logic clr);
    bus.wr_en   = we;
    bus.wr_addr = CS_W'(addr);
    bus.wr_data = N_BITS'(data);
    bus.refresh = rf;
    bus.err_clr = clr;
    stepCycle();
  endtask

  task automatic clearLog();
    logCs.delete(); logData.delete(); logCyc.delete();
  endtask

  task automatic runUntilIdle(input int maxCyc);
    int n;
    n = 0;
    stepCycle();
    stepCycle();
    while (!bus.idle && n < maxCyc) begin
      stepCycle();
      n++;
    end
    checkOutput("reach_idle", 64'(bus.idle), 64'd1);
  endtask

  task automatic waitStarts(input int count, input int maxCyc);
    int n;
    n = 0;
    while (logCs.size() < count && n < maxCyc) begin
      stepCycle();
      n++;
    end
    checkOutput("start_seen", 64'(logCs.size() >= count), 64'd1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_start"},   64'(bus.shf_start), 64'd0);
    checkOutput({tag, "_cs"},      64'(bus.shf_cs),    64'd0);
    checkOutput({tag, "_data"},    64'(bus.shf_data),  64'd0);
    checkOutput({tag, "_err"},     64'(bus.err),       64'd0);
    checkOutput({tag, "_pending"}, 64'(bus.pending),   64'hFFFF);
    checkOutput({tag, "_idle"},    64'(bus.idle),      64'd0);
  endtask

  task automatic checkFullSweep(input string tag);
    checkOutput({tag, "_count"}, 64'(logCs.size()), 64'd16);
    for (int i = 0; i < 16 && i < logCs.size(); i++) begin
      checkOutput({tag, "_cs"},   64'(logCs[i]),   64'(i));
      checkOutput({tag, "_data"}, 64'(logData[i]), 64'hFF);
    end
    checkOutput({tag, "_pending0"}, 64'(bus.pending), 64'd0);
  endtask

  task automatic doMidReset();
    #2 reset = 1'b1;
    modelReset();
    bus.shf_done = 1'b0;
    #1 checkResetOutputs("midrst");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_nostart", 64'(bus.shf_start), 64'd0);
    end
    clearLog();
    reset = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.refresh = 1'b0; bus.err_clr = 1'b0; bus.shf_done = 1'b0;
    #1 reset = 1'b1;
    modelReset();
    #1 checkResetOutputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] power-on sweep of all devices");
    doneDelay = 10;
    clearLog();
    runUntilIdle(600);
    checkFullSweep("sweep");
    if (logCyc.size() >= 2) checkOutput("sweep_spacing", 64'(logCyc[1] - logCyc[0]), 64'd13);

    $display("[TB] single write");
    clearLog();
    applyStimulus(1'b1, 5, 8'h3C, 1'b0, 1'b0);
    runUntilIdle(100);
    checkOutput("wr5_count", 64'(logCs.size()), 64'd1);
    if (logCs.size() >= 1) begin
      checkOutput("wr5_cs",   64'(logCs[0]),   64'd5);
      checkOutput("wr5_data", 64'(logData[0]), 64'h3C);
    end
    checkOutput("wr5_pending", 64'(bus.pending), 64'd0);

    $display("[TB] round-robin order after rr_ptr=9");
    clearLog();
    applyStimulus(1'b1, 9, 8'h99, 1'b0, 1'b0);
    waitStarts(1, 20);
    applyStimulus(1'b1, 2,  8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 9,  8'h9A, 1'b0, 1'b0);
    applyStimulus(1'b1, 14, 8'hEE, 1'b0, 1'b0);
    runUntilIdle(200);
    checkOutput("rr_count", 64'(logCs.size()), 64'd4);
    if (logCs.size() >= 4) begin
      checkOutput("rr_cs0", 64'(logCs[0]), 64'd9);
      checkOutput("rr_cs1", 64'(logCs[1]), 64'd14);
      checkOutput("rr_cs2", 64'(logCs[2]), 64'd2);
      checkOutput("rr_cs3", 64'(logCs[3]), 64'd9);
      checkOutput("rr_data1", 64'(logData[1]), 64'hEE);
      checkOutput("rr_data3", 64'(logData[3]), 64'h9A);
    end

    $display("[TB] rewrite of in-flight device");
    clearLog();
    applyStimulus(1'b1, 3, 8'h22, 1'b0, 1'b0);
    waitStarts(1, 20);
    applyStimulus(1'b1, 3, 8'h11, 1'b0, 1'b0);
    checkOutput("inflight_data", 64'(bus.shf_data), 64'h22);
    runUntilIdle(100);
    checkOutput("inflight_count", 64'(logCs.size()), 64'd2);
    if (logCs.size() >= 2) begin
      checkOutput("inflight_cs1",   64'(logCs[1]),   64'd3);
      checkOutput("inflight_data0", 64'(logData[0]), 64'h22);
      checkOutput("inflight_data1", 64'(logData[1]), 64'h11);
    end

    $display("[TB] done on the last timeout cycle");
    clearLog();
    doneDelay = TIMEOUT;
    applyStimulus(1'b1, 1, 8'h55, 1'b0, 1'b0);
    runUntilIdle(100);
    checkOutput("edge_err",   64'(bus.err),       64'd0);
    checkOutput("edge_count", 64'(logCs.size()),  64'd1);

    $display("[TB] timeout and retry");
    clearLog();
    doneDelay = 0;
    applyStimulus(1'b1, 7, 8'h77, 1'b0, 1'b0);
    waitStarts(1, 20);
    repeat (TIMEOUT + 1) stepCycle();
    checkOutput("tmo_err",     64'(bus.err),        64'd1);
    checkOutput("tmo_pending", 64'(bus.pending[7]), 64'd1);
    doneDelay = 10;
    waitStarts(2, 20);
    if (logCyc.size() >= 2) begin
      checkOutput("tmo_spacing", 64'(logCyc[1] - logCyc[0]), 64'(TIMEOUT + 3));
      checkOutput("tmo_retry_cs", 64'(logCs[1]), 64'd7);
      checkOutput("tmo_retry_data", 64'(logData[1]), 64'h77);
    end
    runUntilIdle(100);
    checkOutput("tmo_sticky", 64'(bus.err), 64'd1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
    checkOutput("errclr", 64'(bus.err), 64'd0);

    $display("[TB] reset in the middle of a transfer");
    clearLog();
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);
    waitStarts(1, 20);
    repeat (4) stepCycle();
    doMidReset();
    runUntilIdle(600);
    checkFullSweep("resweep");

    $display("[TB] randomized traffic");
    noiseOn = 1;
    for (int i = 0; i < 3000; i++) begin
      doneDelay = int'($urandom_range(1, TIMEOUT + 2));
      if (i == 1500) doMidReset();
      applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, N_CS - 1)),
                    int'($urandom_range(0, 255)), $urandom_range(0, 99) == 0,
                    $urandom_range(0, 19) == 0);
    end
    noiseOn = 0;
    doneDelay = 5;
    runUntilIdle(2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
